fetch_sequencer: RTL
====================

# fetch_sequencer

Fetch-stage controller that owns the program counter and sequences the instruction memory read port. It streams fetched words, tagged with their PC, into decode through a 2-entry skid queue with a valid/ready handshake. It also applies redirects (branch/jump resolution, exceptions) by flushing the queue and reloading the PC. It sits between the instruction memory (7-bit byte address in, 32-bit word out, combinational read) and the IF/ID pipeline register.

## Interface
- ADDR_W, 7, byte-address width of PC and memory port; PC arithmetic wraps modulo 2^ADDR_W
- DEPTH, 2, skid-queue entries (legal: 2 only)
- clk  in  1  single clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- fetch_en  in  1  allows new fetches; 0 freezes PC and stops pushes, queue still drains
- mem_add  out  ADDR_W  byte address to instruction memory; equals PC register
- mem_instruc  in  32  word returned combinationally for mem_add
- redirect_valid  in  1  single-cycle redirect strobe
- redirect_pc  in  ADDR_W  redirect target; bits [1:0] ignored and forced to 0
- id_valid  out  1  queue head valid
- id_ready  in  1  decode accepts head this cycle
- id_instruc  out  32  head instruction word
- id_pc  out  ADDR_W  head instruction byte address
- id_pc_plus4  out  ADDR_W  id_pc + 4, wrapped

## Operation
- State: pc (ADDR_W, word-aligned), queue of DEPTH entries {instr, pc}, count (0..DEPTH), rd/wr pointers.
- pop = id_valid & id_ready. push = fetch_en & !redirect_valid & (count < DEPTH | pop).
- On push: enqueue {mem_instruc, pc}; pc <= next_pc. next_pc = pc + 4 (wrap 0x7C -> 0x00).
- On redirect_valid: queue flushed (count <= 0, pointers reset), pc <= {redirect_pc[ADDR_W-1:2], 2'b00}, no push. Redirect has priority over push and pop; a coincident pop is considered consumed, but no queue update beyond the flush occurs.
- Simultaneous push and pop with count == DEPTH: both occur, count unchanged.
- id_* outputs are driven from the queue head. When count == 0, id_valid = 0 and id_instruc, id_pc and id_pc_plus4 hold their last values (they are not zeroed).
- The head is stable while id_valid & !id_ready: no change to id_instruc or id_pc.
- Reset values: pc = 0, count = 0, id_valid = 0, id_instruc = 32'h0, id_pc = 0, id_pc_plus4 = 4, mem_add = 0.

## Timing
- Latency: word at mem_add in cycle N appears at the queue head in cycle N+1 (id_valid = 1) when the queue was empty.
- First cycle after rst_n deasserts (with fetch_en = 1): mem_add = 0, and it is pushed. id_valid rises the next cycle.
- Redirect asserted in cycle N: id_valid = 0 in N+1. mem_add = target in N+1, and the target word is at the head in N+2.
- Sustained throughput with id_ready = 1: one instruction per cycle.
- When id_ready drops, the queue absorbs at most DEPTH words. pc then halts at the address of the first unfetched word.
- rst_n assertion mid-stream: all state clears immediately (asynchronous). Fetch restarts at 0.

## Configuration
- JUMP_PREDECODE_EN defined: when the pushed word has opcode mem_instruc[31:26] == 6'b000010 (J), next_pc = {mem_instruc[ADDR_W-3:0], 2'b00} instead of pc + 4. The J word itself is still enqueued, and the sequential word after it is never fetched.
- JUMP_PREDECODE_EN undefined: J is treated like any other instruction (next_pc = pc + 4). Decode must issue redirect_valid for jumps.

## Test plan
- Reset stream: memory preloaded with 20080001, 8C090004, 01094020, AC080008 at 0x00–0x0C; id_ready = 1 -> id_instruc sequence 20080001, 8C090004, 01094020, AC080008 on consecutive cycles from cycle 1. id_pc = 0x00, 0x04, 0x08, 0x0C; id_pc_plus4 = id_pc + 4.
- Backpressure: id_ready = 0 for 5 cycles from reset -> count saturates at 2, mem_add holds 0x08, and id_instruc holds 20080001. On id_ready = 1, the words 20080001, 8C090004, 01094020 follow with no gap.
- Redirect: redirect_valid with redirect_pc = 0x17 mid-stream -> next cycle id_valid = 0 and mem_add = 0x14. The following cycle gives id_instruc = mem[5] (20080002) with id_pc = 0x14.
- Wrap: redirect to 0x7C -> head id_pc = 0x7C with id_pc_plus4 = 0x00, then next head id_pc = 0x00.
- Jump predecode (macro defined): 08000003 at 0x10 -> head sequence id_pc 0x10, 0x0C, 0x10, 0x0C. Without the macro, the sequence is 0x10, 0x14.
- Async reset: rst_n pulsed low for half a cycle while count = 2 -> id_valid = 0 immediately, mem_add = 0, and the stream restarts with 20080001.

Source files
------------

// File: rtl/fetch_sequencer.sv
// Fetch-stage PC owner: reads instruction memory and streams {instr, pc} to decode through a 2-entry skid queue.
// Optional macro JUMP_PREDECODE_EN: follow J-format targets at fetch instead of falling through to pc + 4.
module fetch_sequencer #(
  parameter int ADDR_W = 7,
  parameter int DEPTH  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fetch_en,
  output logic [ADDR_W-1:0] mem_add,
  input  logic [31:0]       mem_instruc,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              id_valid,
  input  logic              id_ready,
  output logic [31:0]       id_instruc,
  output logic [ADDR_W-1:0] id_pc,
  output logic [ADDR_W-1:0] id_pc_plus4
);

  typedef struct packed {
    logic [31:0]       instr;
    logic [ADDR_W-1:0] pc;
  } entry_t;

  localparam logic [1:0] FULL = 2'(DEPTH);

  entry_t [DEPTH-1:0] ent_q, ent_d;
  entry_t             head_q, head_d;
  logic [1:0]         count_q, count_d;
  logic               rd_q, rd_d, wr_q, wr_d;
  logic [ADDR_W-1:0]  pc_q, pc_d, next_pc;
  logic               push, pop;

  always_comb begin
    pop  = (count_q != 2'd0) & id_ready;
    push = fetch_en & ~redirect_valid & ((count_q < FULL) | pop);

    next_pc = pc_q + ADDR_W'(4);
`ifdef JUMP_PREDECODE_EN
    if (mem_instruc[31:26] == 6'b000010)
      next_pc = {mem_instruc[ADDR_W-3:0], 2'b00};
`endif

    ent_d   = ent_q;
    count_d = count_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    pc_d    = pc_q;

    if (redirect_valid) begin
      // Flush wins over any coincident push/pop.
      count_d = 2'd0;
      rd_d    = 1'b0;
      wr_d    = 1'b0;
      pc_d    = redirect_pc & ~ADDR_W'(3);
    end else begin
      if (push) begin
        ent_d[wr_q] = '{instr: mem_instruc, pc: pc_q};
        wr_d        = ~wr_q;
        pc_d        = next_pc;
      end
      if (pop) rd_d = ~rd_q;
      count_d = count_q + {1'b0, push} - {1'b0, pop};
    end

    // Head is registered so it keeps its last value once the queue empties.
    head_d = head_q;
    if (count_d != 2'd0) head_d = ent_d[rd_d];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ent_q   <= '0;
      head_q  <= '0;
      count_q <= 2'd0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      pc_q    <= '0;
    end else begin
      ent_q   <= ent_d;
      head_q  <= head_d;
      count_q <= count_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      pc_q    <= pc_d;
    end
  end

  assign mem_add     = pc_q;
  assign id_valid    = (count_q != 2'd0);
  assign id_instruc  = head_q.instr;
  assign id_pc       = head_q.pc;
  assign id_pc_plus4 = head_q.pc + ADDR_W'(4);

endmodule
